uart_rx_buffered: RTL and testbench

Serial receive front end of the `computer` top level. Samples the asynchronous `rx` pin, recovers 8N1 frames at `BAUD_RATE` using 16x oversampling, and queues received bytes in a small show-ahead FIFO. The CPU's UART MMIO read path consumes the FIFO. Framing errors and FIFO overruns are reported as status.

---
 rtl/uart_rx_buffered.sv | 157 +++++++++++++++
 tb/tb_uart_rx_buffered.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver, 16x oversampled, with a small show-ahead byte FIFO.
// Framing errors and FIFO overruns are sticky until clr_err.
module uart_rx_buffered #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLOCK_HZ / (BAUD_RATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic          sync1_q;
  logic          rx_s_q;
  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [3:0]    tcnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          push_q;
  logic          frame_err_q;
  logic          tick;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          overrun_q;
  logic          full;
  logic          pop;
  logic          do_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      tcnt_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      div_q  <= tick ? '0 : div_q + DW'(1);
      if (tick) tcnt_q <= tcnt_q + 4'd1;
      if (clr_err) frame_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            div_q   <= '0;
            tcnt_q  <= '0;
          end
        end
        S_START: begin
          if (tick && tcnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_q <= S_DATA;
              bit_q   <= '0;
              tcnt_q  <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tick && tcnt_q == 4'd15) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick && tcnt_q == 4'd15) begin
            if (rx_s_q) begin
              push_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // held-low line must go high before rearming
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_en && rd_valid;
  assign do_push = push_q && (!full || pop);
  assign count_d = count_q + CW'(do_push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (clr_err) overrun_q <= 1'b0;
      if (push_q && full && !pop) overrun_q <= 1'b1;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign rd_valid  = (count_q != '0);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: queue model of the FIFO and
// flags, checked every cycle, plus literal spot checks.
module tb_uart_rx_buffered;

  localparam int BITC  = 434;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  bit         m_fe = 1'b0;
  bit         m_ovr = 1'b0;

  uart_rx_buffered #(
    .CLOCK_HZ  (50_000_000),
    .BAUD_RATE (115200),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h",
                 name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m_valid", rd_valid, mq.size() != 0);
    if (mq.size() != 0) chk("m_data", rd_data, mq[0]);
    chk("m_ferr", frame_err, m_fe);
    chk("m_ovr", overrun, m_ovr);
  end

  function automatic void m_push(input logic [7:0] b,
                                 input bit popfirst);
    if (popfirst && mq.size() != 0) void'(mq.pop_front());
    if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit good,
                            input bit pop_at_push,
                            output int lat);
    int n;
    int idx;
    bit pv;
    n = good ? 10 * BITC : 13 * BITC;
    lat = -1;
    pv = rd_valid;
    rx = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (lat < 0 && rd_valid && !pv) lat = i;
      pv = rd_valid;
      idx = i / BITC;
      if (idx == 0) rx = 1'b0;
      else if (idx <= 8) rx = b[idx-1];
      else if (idx <= 11) rx = good;
      else rx = 1'b1;
      if (i == 4107) begin
        if (pop_at_push) rd_en = 1'b1;
        if (!good) m_fe = 1'b1;
      end
      if (i == 4108) begin
        rd_en = 1'b0;
        if (good) m_push(b, pop_at_push);
      end
    end
    rx = 1'b1;
    repeat (20) step();
  endtask

  task automatic pop(output logic [7:0] d);
    d = rd_data;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    m_fe = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data"}, rd_data, 8'h00);
  endtask

  initial begin
    int lat;
    int rise;
    int fall;
    logic [7:0] d;

    #5;
    chk_reset("rst0");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    send_frame(8'hAA, 1'b1, 1'b0, lat);
    chk("single_lat", (lat >= 4105 && lat <= 4109), 1);
    chk("single_data", rd_data, 8'hAA);
    pop(d);
    chk("single_pop", d, 8'hAA);
    chk("single_empty", rd_valid, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_rden", rd_valid, 0);

    rise = -1;
    fall = -1;
    rx = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (i == 150) rx = 1'b1;
      if (rise < 0 && busy) rise = i;
      if (rise >= 0 && fall < 0 && !busy) fall = i;
    end
    chk("glitch_rise", rise > 0, 1);
    chk("glitch_fall", (fall > 0 && fall <= 220), 1);
    chk("glitch_valid", rd_valid, 0);
    chk("glitch_ferr", frame_err, 0);

    send_frame(8'hAA, 1'b0, 1'b0, lat);
    chk("ferr_set", frame_err, 1);
    chk("ferr_novalid", rd_valid, 0);
    chk("ferr_idle", busy, 0);
    send_frame(8'h55, 1'b1, 1'b0, lat);
    chk("ferr_next", rd_data, 8'h55);
    chk("ferr_sticky", frame_err, 1);
    clear_flags();
    chk("ferr_clr", frame_err, 0);
    pop(d);
    chk("ferr_pop", d, 8'h55);

    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, lat);
      if (v == 4) begin
        chk("ovr_cnt4", dut.count_q, 4);
        chk("ovr_not_yet", overrun, 0);
      end
    end
    chk("ovr_set", overrun, 1);
    for (int k = 1; k <= 4; k++) begin
      pop(d);
      chk("ovr_pop", d, k);
    end
    chk("ovr_empty", rd_valid, 0);
    clear_flags();
    chk("ovr_clr", overrun, 0);

    for (int v = 1; v <= 4; v++)
      send_frame(8'(v), 1'b1, 1'b0, lat);
    send_frame(8'h05, 1'b1, 1'b1, lat);
    chk("pp_no_ovr", overrun, 0);
    for (int k = 2; k <= 5; k++) begin
      pop(d);
      chk("pp_pop", d, k);
    end
    chk("pp_empty", rd_valid, 0);

    rx = 1'b0;
    repeat (BITC) step();
    rx = 1'b1;
    repeat (1500) step();
    rst_n = 1'b0;
    mq.delete();
    m_fe = 1'b0;
    m_ovr = 1'b0;
    #1;
    chk_reset("rstm");
    repeat (3) step();
    chk_reset("rstm2");
    rst_n = 1'b1;
    repeat (10) step();
    send_frame(8'hC3, 1'b1, 1'b0, lat);
    pop(d);
    chk("rst_c3", d, 8'hC3);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_empty", rd_valid, 0);

    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
